// File: rtl/dmem_mmio_pkg.sv
// Shared address map and UART state encoding for the data-memory/MMIO stage.
// Pure declarations: no latency, no flow control.
package dmem_mmio_pkg;

  localparam logic [31:0] MMIO_MASK      = 32'h8000_0000;
  localparam logic [31:0] LED_ADDR       = 32'h8000_0000;
  localparam logic [31:0] TIMER_ADDR     = 32'h8000_0004;
  localparam logic [31:0] UART_DATA_ADDR = 32'h8000_0008;
  localparam logic [31:0] UART_STAT_ADDR = 32'h8000_000C;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/dmem_mmio_uart_tx.sv
// 8N1 serial transmitter; tx goes low the cycle after start is accepted, frame lasts 10*CLKS_PER_BIT cycles.
// No backpressure: start is only honoured while idle, starts during a frame are dropped.
module uart_tx
  import dmem_mmio_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  uart_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          bit_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CW'(1);
    idx_d    = idx_q;
    shift_d  = shift_q;
    bit_done = (cnt_q == LAST);
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) begin
          shift_d = data;
          state_d = START;
        end
      end
      START: begin
        if (bit_done) begin
          state_d = DATA;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (bit_done) begin
          cnt_d = '0;
          if (idx_q == 3'd7) begin
            state_d = STOP;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (bit_done) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  // Decoded straight from state so an async reset forces the line high at once.
  always_comb begin
    tx = 1'b1;
    unique case (state_q)
      START:   tx = 1'b0;
      DATA:    tx = shift_q[idx_q];
      default: tx = 1'b1;
    endcase
  end

  assign busy = (state_q != IDLE);

endmodule

// File: rtl/dmem_mmio.sv
// Data memory plus MMIO (LED, timer, UART); loads are combinational, stores land on the clock edge.
// No backpressure: UART writes issued while busy are silently dropped.
module dmem_mmio
  import dmem_mmio_pkg::*;
#(
  parameter int RAM_WORDS    = 64,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] A,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  output logic [7:0]  leds,
  output logic        uart_tx
);

  localparam int AW = $clog2(RAM_WORDS);

  logic [31:0]   mem [RAM_WORDS];
  logic [AW-1:0] ram_idx;
  logic [31:0]   word_addr;
  logic          sel_ram, sel_led, sel_timer, sel_uart_data, sel_uart_stat;
  logic [7:0]    leds_q, leds_d;
  logic [31:0]   timer_q, timer_d;
  logic          uart_start, uart_busy;
  logic          unused_ok;

  assign unused_ok = &{1'b0, A[1:0]};

  assign ram_idx       = A[AW+1:2];
  assign word_addr     = {A[31:2], 2'b00};
  assign sel_ram       = ((A & MMIO_MASK) == 32'd0);
  assign sel_led       = (word_addr == LED_ADDR);
  assign sel_timer     = (word_addr == TIMER_ADDR);
  assign sel_uart_data = (word_addr == UART_DATA_ADDR);
  assign sel_uart_stat = (word_addr == UART_STAT_ADDR);

  // RAM is deliberately left out of reset so it maps onto distributed/block RAM.
  always_ff @(posedge clk) begin
    if (MemWrite && sel_ram) begin
      mem[ram_idx] <= WD;
    end
  end

  always_comb begin
    leds_d  = leds_q;
    timer_d = timer_q + 32'd1;
    if (MemWrite && sel_led) begin
      leds_d = WD[7:0];
    end
    if (MemWrite && sel_timer) begin
      timer_d = WD;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      leds_q  <= '0;
      timer_q <= '0;
    end else begin
      leds_q  <= leds_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    RD = 32'd0;
    if (sel_ram) begin
      RD = mem[ram_idx];
    end else if (sel_led) begin
      RD = {24'd0, leds_q};
    end else if (sel_timer) begin
      RD = timer_q;
    end else if (sel_uart_stat) begin
      RD = {31'd0, uart_busy};
    end
  end

  assign uart_start = MemWrite && sel_uart_data;
  assign leds       = leds_q;

  uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clk  (clk),
    .reset(reset),
    .start(uart_start),
    .data (WD[7:0]),
    .tx   (uart_tx),
    .busy (uart_busy)
  );

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed bench for dmem_mmio: RAM, LED, timer and UART framing with hand-computed expectations.
module tb_dmem_mmio;

  localparam logic [31:0] A_LED  = 32'h8000_0000;
  localparam logic [31:0] A_TMR  = 32'h8000_0004;
  localparam logic [31:0] A_UDAT = 32'h8000_0008;
  localparam logic [31:0] A_USTA = 32'h8000_000C;

  logic        clk;
  logic        reset;
  logic        MemWrite;
  logic [31:0] A;
  logic [31:0] WD;
  logic [31:0] RD;
  logic [7:0]  leds;
  logic        uart_tx;

  int n_chk;
  int n_pass;

  dmem_mmio #(
    .RAM_WORDS   (64),
    .CLKS_PER_BIT(4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .MemWrite(MemWrite),
    .A       (A),
    .WD      (WD),
    .RD      (RD),
    .leds    (leds),
    .uart_tx (uart_tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    A        = addr;
    WD       = data;
    MemWrite = 1'b1;
    step();
    MemWrite = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    A        = addr;
    MemWrite = 1'b0;
    #1;
    chk(tag, RD, exp);
  endtask

  // Expected line level k cycles after the accepting edge of a frame carrying d.
  function automatic logic exp_tx(input int k, input logic [7:0] d);
    int b;
    b = k / 4;
    if (b == 0) return 1'b0;
    if (b >= 9) return 1'b1;
    return d[b-1];
  endfunction

  initial begin
    logic [7:0] d55;
    d55      = 8'h55;
    n_chk    = 0;
    n_pass   = 0;
    reset    = 1'b1;
    MemWrite = 1'b0;
    A        = 32'd0;
    WD       = 32'd0;

    repeat (3) step();
    chk("rst_leds", {24'd0, leds}, 32'h0000_0000);
    chk("rst_tx", {31'd0, uart_tx}, 32'd1);
    rd_chk("rst_stat", A_USTA, 32'd0);
    rd_chk("rst_timer", A_TMR, 32'd0);

    step();
    reset = 1'b0;
    repeat (10) step();
    rd_chk("timer_10", A_TMR, 32'd10);

    step();
    wr(32'h0000_0010, 32'hDEAD_BEEF);
    rd_chk("ram_rd", 32'h0000_0010, 32'hDEAD_BEEF);
    rd_chk("ram_alias", 32'h0000_0110, 32'hDEAD_BEEF);
    rd_chk("ram_lowbits", 32'h0000_0013, 32'hDEAD_BEEF);

    step();
    A        = 32'h0000_0010;
    WD       = 32'h1111_2222;
    MemWrite = 1'b1;
    #1;
    chk("ram_rd_during_wr", RD, 32'hDEAD_BEEF);
    step();
    MemWrite = 1'b0;
    rd_chk("ram_after_wr", 32'h0000_0010, 32'h1111_2222);

    step();
    wr(A_LED, 32'h1234_56A5);
    chk("led_out", {24'd0, leds}, 32'h0000_00A5);
    rd_chk("led_rd", A_LED, 32'h0000_00A5);
    wr(32'h8000_0010, 32'hFFFF_FFFF);
    chk("unmapped_wr_led", {24'd0, leds}, 32'h0000_00A5);
    rd_chk("unmapped_rd", 32'h8000_0010, 32'd0);
    rd_chk("udata_rd", A_UDAT, 32'd0);

    step();
    wr(A_TMR, 32'hFFFF_FFFE);
    rd_chk("timer_ld", A_TMR, 32'hFFFF_FFFE);
    step();
    rd_chk("timer_max", A_TMR, 32'hFFFF_FFFF);
    step();
    rd_chk("timer_wrap", A_TMR, 32'h0000_0000);

    step();
    rd_chk("stat_idle", A_USTA, 32'd0);
    step();
    wr(A_UDAT, 32'h0000_0055);
    for (int k = 0; k < 40; k++) begin
      A = A_USTA;
      #1;
      chk($sformatf("f1_tx_%0d", k), {31'd0, uart_tx}, {31'd0, exp_tx(k, d55)});
      chk($sformatf("f1_busy_%0d", k), RD, 32'd1);
      step();
    end
    rd_chk("f1_done_busy", A_USTA, 32'd0);
    chk("f1_done_tx", {31'd0, uart_tx}, 32'd1);

    // Second frame starts in the very first idle cycle; a store mid-frame must be dropped.
    wr(A_UDAT, 32'h0000_0055);
    for (int k = 0; k < 40; k++) begin
      if (k == 6) begin
        A        = A_UDAT;
        WD       = 32'h0000_00FF;
        MemWrite = 1'b1;
        #1;
        chk($sformatf("f2_tx_%0d", k), {31'd0, uart_tx}, {31'd0, exp_tx(k, d55)});
        step();
        MemWrite = 1'b0;
      end else begin
        A = A_USTA;
        #1;
        chk($sformatf("f2_tx_%0d", k), {31'd0, uart_tx}, {31'd0, exp_tx(k, d55)});
        chk($sformatf("f2_busy_%0d", k), RD, 32'd1);
        step();
      end
    end
    for (int k = 0; k < 12; k++) begin
      A = A_USTA;
      #1;
      chk($sformatf("f2_idle_tx_%0d", k), {31'd0, uart_tx}, 32'd1);
      chk($sformatf("f2_idle_busy_%0d", k), RD, 32'd0);
      step();
    end

    wr(A_UDAT, 32'h0000_0055);
    repeat (12) step();
    rd_chk("mid_busy", A_USTA, 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_tx", {31'd0, uart_tx}, 32'd1);
    chk("mid_rst_busy", RD, 32'd0);
    chk("mid_rst_leds", {24'd0, leds}, 32'd0);
    step();
    reset = 1'b0;
    for (int k = 0; k < 50; k++) begin
      A = A_USTA;
      #1;
      chk($sformatf("post_rst_tx_%0d", k), {31'd0, uart_tx}, 32'd1);
      chk($sformatf("post_rst_busy_%0d", k), RD, 32'd0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dmem_mmio.md
# dmem_mmio

Data-memory stage for the single-cycle RISC-V core: consumes the datapath's ALUResult (address), WriteData and the controller's MemWrite, and returns ReadData in the same cycle. Besides a word-addressed RAM it decodes a small memory-mapped I/O region: an LED register, a free-running 32-bit timer and an 8N1 UART transmitter. It lets test programs produce visible output on the FPGA board.

## Interface
- RAM_WORDS, 64: RAM depth in 32-bit words; must be a power of two, at least 4.
- CLKS_PER_BIT, 434: UART bit period in clk cycles; must be at least 2.

- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- MemWrite  in  1  store strobe from the controller.
- A  in  32  byte address (datapath ALUResult).
- WD  in  32  store data (datapath WriteData).
- RD  out  32  load data (datapath ReadData); combinational from A.
- leds  out  8  LED register.
- uart_tx  out  1  serial line; idles high.

## Operation
- Address decode, with A[1:0] ignored everywhere:
  - A[31]=0 selects RAM. The word index is A[log2(RAM_WORDS)+1:2]; higher bits alias.
  - 0x8000_0000 is LED, RW. Bits 7:0 are used; reads return zero-extended bits.
  - 0x8000_0004 is TIMER, RW.
  - 0x8000_0008 is UART_DATA, write-only; reads return 0.
  - 0x8000_000C is UART_STAT, RO. Bit0 is busy; other bits read 0.
  - Any other A[31]=1 address reads 0 and ignores writes.
- RAM:
  - Write on the rising edge when MemWrite=1; full word only.
  - Read is asynchronous.
  - A read in the same cycle as a write to the same word returns the old data.
  - RAM contents are not reset.
- TIMER:
  - Increments by 1 every cycle and wraps from 0xFFFF_FFFF to 0.
  - A write loads WD at the edge; no increment occurs in that cycle.
  - Reads return the current registered value.
- UART transmitter, states IDLE, START, DATA, STOP:
  - IDLE: uart_tx=1. A write to UART_DATA latches WD[7:0] and moves to START at that edge.
  - START: uart_tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: uart_tx = shift[idx], LSB first, each bit held CLKS_PER_BIT cycles. After bit 7, go to STOP.
  - STOP: uart_tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
  - busy = (state != IDLE).
  - A write to UART_DATA while busy is ignored; the frame in progress is unaffected.
  - A bit counter counts 0..CLKS_PER_BIT-1 and a 3-bit index selects the data bit. Both are cleared on every state change.
- Reset values:
  - RD follows A; RAM contents are undefined after reset.
  - leds=0, uart_tx=1, timer=0.
  - UART is IDLE with busy=0 and the shift register at 0.
- Reset asserted mid-frame: uart_tx returns to 1 immediately (asynchronously), and no partial frame resumes after reset deasserts.

## Timing
- Loads have zero latency: RD is valid in the same cycle as A.
- Stores, LED writes and timer writes take effect at the edge where MemWrite=1.
- UART frame:
  - uart_tx falls in the first cycle after the accepting edge.
  - A frame lasts exactly 10·CLKS_PER_BIT cycles; busy is 1 for all of them.
  - A new write is accepted in the first cycle busy reads 0.
  - Back-to-back frames therefore have no idle gap beyond that one cycle.
- UART_STAT read in the same cycle as the accepting write returns busy=0. busy=1 is visible from the next cycle.

## Structure
- Package dmem_mmio_pkg holds:
  - address constants LED_ADDR, TIMER_ADDR, UART_DATA_ADDR, UART_STAT_ADDR;
  - the MMIO base mask;
  - typedef enum uart_state_t {IDLE, START, DATA, STOP}.
- One sub-module, uart_tx.
  - Parameter: CLKS_PER_BIT.
  - Ports: clk, reset, start, data[7:0], tx, busy.
- dmem_mmio itself holds the decode logic, the RAM array, the LED register and the timer.

## Test plan
- RAM store/load: write 0xDEADBEEF to 0x0000_0010, then read 0x0000_0010 → RD=0xDEADBEEF.
  - With RAM_WORDS=64, reading 0x0000_0110 (aliased) also returns 0xDEADBEEF.
- LED: reset → leds=0x00. Store 0x1234_56A5 to 0x8000_0000 → leds=0xA5 next cycle; a read returns 0x0000_00A5.
- Timer:
  - Read 10 cycles after reset deasserts → RD=10.
  - Store 0xFFFF_FFFE → reads 0xFFFF_FFFE, then 0xFFFF_FFFF, then 0x0000_0000 on the following cycles.
- UART frame (CLKS_PER_BIT=4): store 0x55 to 0x8000_0008 → over 40 cycles uart_tx is 0,1,0,1,0,1,0,1,0,1 per 4-cycle bit; busy=1 throughout, then 0.
- UART busy writes: during a 0x55 frame, store 0xFF to UART_DATA → the frame is unchanged and no second frame starts.
- Reset mid-frame: assert reset 12 cycles into a frame → uart_tx=1 and busy=0 immediately; after release, uart_tx stays 1 with no further transitions.
